// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL register models: mode-select encodings
// presented on the {S1,S0} pins.
package ttl_pkg;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
endpackage

// File: rtl/ls299.sv
// 74LS299-style universal shift/storage register with the bidirectional
// I/O pins split into input, output and output-enable signals.
module ls299
    import ttl_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             S0,
    input  logic             S1,
    input  logic             G1_n,
    input  logic             G2_n,
    input  logic             DS0,
    input  logic             DS7,
    input  logic [WIDTH-1:0] IO_IN,
    output logic [WIDTH-1:0] IO_OUT,
    output logic             IO_OE,
    output logic             Q0P,
    output logic             Q7P
);
    logic [WIDTH-1:0] q;

    // "Right" moves data toward the MSB (Q0 -> Q7), matching the part's pinout.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            q <= RESET_VAL;
        end else begin
            unique case ({S1, S0})
                MODE_HOLD: q <= q;
                MODE_SHR:  q <= {q[WIDTH-2:0], DS0};
                MODE_SHL:  q <= {DS7, q[WIDTH-1:1]};
                MODE_LOAD: q <= IO_IN;
            endcase
        end
    end

    // Load mode turns the pins around to input whatever the enables say.
    assign IO_OE  = ~G1_n & ~G2_n & ~(S0 & S1);
    assign IO_OUT = q;
    assign Q0P    = q[0];
    assign Q7P    = q[WIDTH-1];
endmodule
